// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding and request/response records at the default widths.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;
    localparam int APB_WAIT_W = 8;

    typedef logic [APB_ADDR_W-1:0] apb_addr_t;
    typedef logic [APB_DATA_W-1:0] apb_data_t;
    typedef logic [APB_STRB_W-1:0] apb_strb_t;
    typedef logic [APB_WAIT_W-1:0] apb_wait_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic      write;
        apb_addr_t addr;
        apb_data_t wdata;
        apb_strb_t strb;
    } apb_req_t;

    // "wait" is a reserved word, hence wait_cnt.
    typedef struct packed {
        apb_data_t rdata;
        logic      err;
        apb_wait_t wait_cnt;
    } apb_rsp_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; signal suffixes follow the slave's point of view.
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic pclk_i,
    input logic preset_ni
);

    logic [ADDR_WIDTH-1:0]   paddr_i;
    logic                    psel_i;
    logic                    penable_i;
    logic                    pwrite_i;
    logic [DATA_WIDTH-1:0]   pwdata_i;
    logic [DATA_WIDTH/8-1:0] pstrb_i;
    logic [DATA_WIDTH-1:0]   prdata_o;
    logic                    pready_o;
    logic                    pslverr_o;

    modport master (
        input  pclk_i, preset_ni, prdata_o, pready_o, pslverr_o,
        output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i
    );

    modport slave (
        input  pclk_i, preset_ni, paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );

endinterface

// File: rtl/apb_master_sva.sv
// Protocol checks on the initiator side of the APB link and its response port.
module apb_master_sva #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic                    psel,
    input logic                    penable,
    input logic                    pwrite,
    input logic [ADDR_WIDTH-1:0]   paddr,
    input logic [DATA_WIDTH-1:0]   pwdata,
    input logic [DATA_WIDTH/8-1:0] pstrb,
    input logic                    pready,
    input logic                    rsp_valid,
    input logic                    rsp_ready
);

    a_setup_to_access: assert property (@(posedge clk) disable iff (!rst_n)
        (psel && !penable) |=> (psel && penable && $stable({pwrite, paddr, pwdata, pstrb})));

    a_access_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (psel && penable && !pready) |=> (psel && penable && $stable({pwrite, paddr, pwdata, pstrb})));

    a_penable_with_psel: assert property (@(posedge clk) disable iff (!rst_n)
        penable |-> psel);

    a_penable_after_setup: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(penable) |-> $past(psel && !penable));

    a_no_setup_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready && !psel) |=> !psel);

endmodule

// File: rtl/apb_master.sv
// APB initiator: one request at a time through SETUP/ACCESS, completion held in a one-entry response register.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WAIT_CNT_WIDTH = 8
) (
    apb_if.master                   apb,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [WAIT_CNT_WIDTH-1:0] rsp_wait_o,
    output logic                    busy_o,
    output logic [1:0]              dbg_state_o
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_ACCESS = ACCESS;

    logic [1:0]                state;
    logic                      write_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;
    logic [WAIT_CNT_WIDTH-1:0] wait_q;

    // Handshake: a request transfers on a clock edge where req_valid_i && req_ready_o;
    // a response transfers where rsp_valid_o && rsp_ready_i. Neither valid may depend on its ready.
    assign req_ready_o = (state == ST_IDLE) && (!rsp_valid_o || rsp_ready_i);
    assign busy_o      = (state != ST_IDLE);
    assign dbg_state_o = state;

    assign apb.psel_i    = (state != ST_IDLE);
    assign apb.penable_i = (state == ST_ACCESS);
    assign apb.pwrite_i  = write_q;
    assign apb.paddr_i   = addr_q;
    assign apb.pwdata_i  = wdata_q;
    assign apb.pstrb_i   = strb_q;

    always_ff @(posedge apb.pclk_i) begin
        if (!apb.preset_ni) begin
            state       <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            wait_q      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            rsp_wait_o  <= '0;
        end else begin
            // A capture below overrides this clear in the same cycle.
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        state   <= ST_SETUP;
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        strb_q  <= req_write_i ? req_strb_i : '0;
                        wait_q  <= '0;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb.pready_o) begin
                        state       <= ST_IDLE;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= write_q ? '0 : apb.prdata_o;
                        rsp_err_o   <= apb.pslverr_o;
                        rsp_wait_o  <= wait_q;
                    end else if (wait_q != '1) begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a behavioural APB slave plus a response scoreboard.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = 8;
    localparam int SW = DW / 8;
    localparam int EW = DW + 1 + WW;
    localparam int PW = AW + DW + SW + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb (.pclk_i(clk), .preset_ni(rst_n));

    logic          req_valid = 1'b0;
    logic          req_ready_o;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic          rsp_valid_o;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic [WW-1:0] rsp_wait_o;
    logic          busy_o;
    logic [1:0]    dbg_state_o;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CNT_WIDTH(WW)) dut (
        .apb         (apb),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_wait_o  (rsp_wait_o),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    apb_master_sva #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_sva (
        .clk       (clk),
        .rst_n     (rst_n),
        .psel      (apb.psel_i),
        .penable   (apb.penable_i),
        .pwrite    (apb.pwrite_i),
        .paddr     (apb.paddr_i),
        .pwdata    (apb.pwdata_i),
        .pstrb     (apb.pstrb_i),
        .pready    (apb.pready_o),
        .rsp_valid (rsp_valid_o),
        .rsp_ready (rsp_ready)
    );

    int            n_tests = 0;
    int            n_fail = 0;
    logic [EW-1:0] exp_q[$];

    // Slave behaviour for the current transfer.
    int            cfg_waits = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic          cfg_err = 1'b0;
    int            waited = 0;

    // Slave: inserts cfg_waits low-pready cycles per ACCESS, with junk data/err while waiting.
    initial begin
        apb.pready_o  = 1'b0;
        apb.prdata_o  = '0;
        apb.pslverr_o = 1'b0;
        forever begin
            @(negedge clk);
            if (apb.psel_i && apb.penable_i) begin
                if (waited < cfg_waits) begin
                    apb.pready_o  = 1'b0;
                    apb.prdata_o  = $urandom;
                    apb.pslverr_o = 1'($urandom);
                    waited++;
                end else begin
                    apb.pready_o  = 1'b1;
                    apb.prdata_o  = cfg_rdata;
                    apb.pslverr_o = cfg_err;
                end
            end else begin
                apb.pready_o  = 1'b0;
                apb.pslverr_o = 1'b0;
                apb.prdata_o  = $urandom;
                waited        = 0;
            end
        end
    end

    // Driver + monitor for one transfer; called at a negedge, returns at the negedge where rsp_valid_o is seen.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input int waits, input logic [DW-1:0] rdata,
                           input logic err, output int hs_cyc);
        logic [EW-1:0] exp_r, got_r;
        logic [PW-1:0] exp_p, got_p;
        logic [SW-1:0] exp_strb;
        bit            hs, ok_acc;
        int            k;
        cfg_waits = waits;
        cfg_rdata = rdata;
        cfg_err   = err;
        exp_strb  = wr ? strb : '0;
        exp_q.push_back({(wr ? {DW{1'b0}} : rdata), err, ((waits > 255) ? 8'hFF : 8'(waits))});
        hs_cyc    = 0;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        req_valid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            #1;
            if (req_ready_o === 1'b1) hs = 1'b1;
            else @(negedge clk);
        end
        n_tests++;
        if (!hs) begin
            $display("FAIL handshake: req_ready_o=%b, required 1 within 20 cycles", req_ready_o);
            n_fail++;
            req_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        hs_cyc = cyc;
        got_p = {apb.psel_i, apb.penable_i, apb.pwrite_i, apb.paddr_i, apb.pwdata_i, apb.pstrb_i, busy_o};
        exp_p = {1'b1, 1'b0, wr, addr, wdata, exp_strb, 1'b1};
        n_tests++;
        if (got_p !== exp_p) begin
            $display("FAIL setup: psel/pen/pwrite/paddr/pwdata/pstrb/busy got %h required %h", got_p, exp_p);
            n_fail++;
        end
        ok_acc = 1'b1;
        k = 1;
        while (k < waits + 10) begin
            @(negedge clk);
            k++;
            if (rsp_valid_o === 1'b1) break;
            got_p = {apb.psel_i, apb.penable_i, apb.pwrite_i, apb.paddr_i, apb.pwdata_i, apb.pstrb_i, busy_o};
            if (got_p !== {1'b1, 1'b1, wr, addr, wdata, exp_strb, 1'b1}) ok_acc = 1'b0;
        end
        n_tests++;
        if (!ok_acc) begin
            $display("FAIL access_stable: bus got %h, required stable %h", got_p,
                     {1'b1, 1'b1, wr, addr, wdata, exp_strb, 1'b1});
            n_fail++;
        end
        n_tests++;
        if (rsp_valid_o !== 1'b1 || k != waits + 3) begin
            $display("FAIL latency: rsp_valid_o=%b after %0d cycles, required 1 after %0d", rsp_valid_o, k, waits + 3);
            n_fail++;
        end
        exp_r = exp_q.pop_front();
        got_r = {rsp_rdata_o, rsp_err_o, rsp_wait_o};
        n_tests++;
        if (got_r !== exp_r) begin
            $display("FAIL response: rdata/err/wait got %h required %h", got_r, exp_r);
            n_fail++;
        end
        n_tests++;
        if ({busy_o, apb.psel_i, apb.penable_i} !== 3'b000) begin
            $display("FAIL idle_after: busy/psel/pen got %b required 000", {busy_o, apb.psel_i, apb.penable_i});
            n_fail++;
        end
    endtask

    task automatic test_reset();
        logic [PW-1:0] got_p;
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        got_p = {apb.psel_i, apb.penable_i, apb.pwrite_i, apb.paddr_i, apb.pwdata_i, apb.pstrb_i, busy_o};
        n_tests++;
        if (got_p !== '0) begin
            $display("FAIL reset_bus: got %h required 0", got_p);
            n_fail++;
        end
        n_tests++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_wait_o} !== '0) begin
            $display("FAIL reset_rsp: got %h required 0", {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_wait_o});
            n_fail++;
        end
        n_tests++;
        if (req_ready_o !== 1'b1 || dbg_state_o !== IDLE) begin
            $display("FAIL reset_ready: req_ready_o=%b state=%0d required 1 and %0d", req_ready_o, dbg_state_o, IDLE);
            n_fail++;
        end
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_write();
        int hs;
        do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, $urandom, 1'b0, hs);
    endtask

    task automatic test_wait_read();
        int hs;
        do_xfer(1'b0, 32'h20, $urandom, 4'hF, 3, 32'h12345678, 1'b0, hs);
    endtask

    task automatic test_slverr();
        int hs;
        do_xfer(1'b1, 32'h30, 32'hCAFEF00D, 4'h3, 1, $urandom, 1'b1, hs);
        do_xfer(1'b0, 32'h34, $urandom, 4'h0, 0, 32'hA5A55A5A, 1'b0, hs);
    endtask

    task automatic test_back_to_back();
        int hs[4];
        for (int i = 0; i < 4; i++) do_xfer(1'b0, 32'h100 + 32'(4 * i), $urandom, $urandom, 0, $urandom, 1'b0, hs[i]);
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (hs[i] - hs[i-1] != 3) begin
                $display("FAIL b2b_spacing[%0d]: got %0d cycles required 3", i, hs[i] - hs[i-1]);
                n_fail++;
            end
        end
    endtask

    task automatic test_rsp_hold();
        int            hs;
        bit            held_ok;
        logic [EW-1:0] snap;
        logic [DW-1:0] r2;
        @(negedge clk);
        rsp_ready = 1'b0;
        do_xfer(1'b0, 32'h200, $urandom, 4'hF, 1, 32'h0BADCAFE, 1'b0, hs);
        snap      = {rsp_rdata_o, rsp_err_o, rsp_wait_o};
        r2        = $urandom;
        cfg_waits = 0;
        cfg_rdata = r2;
        cfg_err   = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h204;
        req_valid = 1'b1;
        held_ok   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || apb.psel_i !== 1'b0 ||
                {rsp_rdata_o, rsp_err_o, rsp_wait_o} !== snap) held_ok = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if (!held_ok) begin
            $display("FAIL rsp_hold: req_ready=%b rsp_valid=%b psel=%b rsp=%h required 0 1 0 %h",
                     req_ready_o, rsp_valid_o, apb.psel_i, {rsp_rdata_o, rsp_err_o, rsp_wait_o}, snap);
            n_fail++;
        end
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            $display("FAIL release_ready: req_ready_o=%b required 1", req_ready_o);
            n_fail++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++;
        if ({rsp_valid_o, apb.psel_i, apb.penable_i, apb.paddr_i} !== {3'b010, 32'h204}) begin
            $display("FAIL release_setup: valid/psel/pen/paddr got %h required %h",
                     {rsp_valid_o, apb.psel_i, apb.penable_i, apb.paddr_i}, {3'b010, 32'h204});
            n_fail++;
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_wait_o} !== {1'b1, r2, 1'b0, 8'd0}) begin
            $display("FAIL release_rsp: got %h required %h", {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_wait_o},
                     {1'b1, r2, 1'b0, 8'd0});
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        int hs;
        @(negedge clk);
        cfg_waits = 10;
        req_write = 1'b0;
        req_addr  = 32'h300;
        req_valid = 1'b1;
        #1;
        n_tests++;
        if (req_ready_o !== 1'b1) begin
            $display("FAIL midrst_ready: req_ready_o=%b required 1", req_ready_o);
            n_fail++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if ({apb.psel_i, apb.penable_i, rsp_valid_o, busy_o} !== 4'b0000) begin
            $display("FAIL midrst: psel/pen/rsp_valid/busy got %b required 0000",
                     {apb.psel_i, apb.penable_i, rsp_valid_o, busy_o});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer(1'b1, 32'h304, $urandom, 4'hC, 2, $urandom, 1'b0, hs);
    endtask

    task automatic test_saturate();
        int hs;
        do_xfer(1'b0, 32'h400, $urandom, 4'hF, 300, $urandom, 1'b0, hs);
    endtask

    task automatic test_random();
        int hs;
        for (int i = 0; i < 16; i++) begin
            do_xfer(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 6), $urandom,
                    1'($urandom), hs);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within 500000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_back_to_back();
        test_rsp_hold();
        test_reset_mid();
        test_saturate();
        test_random();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
